// File: rtl/r4_fft_sched_if.sv
// Control, sample/result and butterfly-datapath signals of the radix-4 FFT scheduler.
// slave is the scheduler side, master the environment driving it.
interface r4_fft_sched_if;
  logic       start;
  logic       abort;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       busy;
  logic       done;
  logic [3:0] bf_xr0, bf_xr1, bf_xr2, bf_xr3;
  logic [3:0] bf_xi0, bf_xi1, bf_xi2, bf_xi3;
  logic       bf_c1, bf_c2, bf_c3;
  logic [3:0] bf_xro, bf_xio;

  modport slave (
    input  start, abort, wr_en, wr_addr, wr_data, rd_addr, bf_xro, bf_xio,
    output rd_data, busy, done,
    output bf_xr0, bf_xr1, bf_xr2, bf_xr3, bf_xi0, bf_xi1, bf_xi2, bf_xi3,
    output bf_c1, bf_c2, bf_c3
  );

  modport master (
    output start, abort, wr_en, wr_addr, wr_data, rd_addr, bf_xro, bf_xio,
    input  rd_data, busy, done,
    input  bf_xr0, bf_xr1, bf_xr2, bf_xr3, bf_xi0, bf_xi1, bf_xi2, bf_xi3,
    input  bf_c1, bf_c2, bf_c3
  );
endinterface

// File: rtl/r4_fft_sched.sv
// 16-point radix-4 FFT scheduler: two ping-pong banks, two stages of four
// 4-input butterflies issued one output per cycle to an external datapath.
module r4_fft_sched (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  r4_fft_sched_if.slave bus
);
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CNT_W = 5;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [DW-1:0]    r_rd_data;
  logic [DW-1:0]    r_bank_a [DEPTH];
  logic [DW-1:0]    r_bank_b [DEPTH];

  logic             w_run;
  logic             w_s;
  logic [1:0]       w_g;
  logic [1:0]       w_k;
  logic [DW-1:0]    w_op [4];
  logic [DW-1:0]    w_res;
  logic [3:0]       w_rd_idx;

  assign w_run    = (r_state == ST_RUN);
  assign w_s      = r_cnt[4];
  assign w_g      = r_cnt[3:2];
  assign w_k      = r_cnt[1:0];
  assign w_res    = {bus.bf_xio, bus.bf_xro};
  assign w_rd_idx = {bus.rd_addr[1:0], bus.rd_addr[3:2]};

  // Stage 0 gathers stride-4 from A, stage 1 gathers contiguous from B.
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      w_op[n] = '0;
      if (w_run) begin
        w_op[n] = w_s ? r_bank_b[{w_g, 2'(n)}] : r_bank_a[{2'(n), w_g}];
      end
    end
  end

  assign bus.bf_xr0 = w_op[0][3:0];
  assign bus.bf_xr1 = w_op[1][3:0];
  assign bus.bf_xr2 = w_op[2][3:0];
  assign bus.bf_xr3 = w_op[3][3:0];
  assign bus.bf_xi0 = w_op[0][7:4];
  assign bus.bf_xi1 = w_op[1][7:4];
  assign bus.bf_xi2 = w_op[2][7:4];
  assign bus.bf_xi3 = w_op[3][7:4];
  assign bus.bf_c1  = w_run & w_k[0];
  assign bus.bf_c2  = w_run & w_k[1];
  assign bus.bf_c3  = w_run & ~w_s & (w_g != 2'd0);

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.rd_data = r_rd_data;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rd_data <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_bank_a[i] <= '0;
        r_bank_b[i] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_rd_data <= r_bank_a[w_rd_idx];
          if (bus.wr_en) r_bank_a[bus.wr_addr] <= bus.wr_data;
          if (bus.start) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
          end
        end
        ST_RUN: begin
          if (bus.abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            if (w_s) r_bank_a[{w_g, w_k}] <= w_res;
            else     r_bank_b[{w_k, w_g}] <= w_res;
            r_cnt <= r_cnt + CNT_W'(1);
            // Terminal count: counter wraps to 0 on this same edge.
            if (r_cnt == CNT_W'(31)) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_rd_data <= r_bank_a[w_rd_idx];
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_r4_fft_sched.sv
// Scoreboard bench for r4_fft_sched: stimulus queues expected run cycles,
// done pulses and read/zero events; a negedge monitor pops and compares.
module tb_r4_fft_sched;
  logic clk;
  logic rst_n;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  logic fin   = 1'b0;

  r4_fft_sched_if bus ();

  r4_fft_sched dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .bus       (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Butterfly stand-in: xro = operand (k+1) mod 4, xio = 0.
  logic [1:0] bm_sel;
  logic [3:0] bm_xro;
  always_comb bm_sel = {bus.bf_c2, bus.bf_c1} + 2'd1;
  always_comb begin
    bm_xro = bus.bf_xr0;
    case (bm_sel)
      2'd1:    bm_xro = bus.bf_xr1;
      2'd2:    bm_xro = bus.bf_xr2;
      2'd3:    bm_xro = bus.bf_xr3;
      default: bm_xro = bus.bf_xr0;
    endcase
  end
  assign bus.bf_xro = bm_xro;
  assign bus.bf_xio = 4'h0;

  typedef struct {
    int          cyc;
    logic [15:0] xr;
    logic [15:0] xi;
    logic [2:0]  ctl;
  } run_t;

  typedef struct {
    int         cyc;
    int         kind;  // 0: rd_data value, 1: all outputs zero
    logic [7:0] val;
  } ev_t;

  run_t run_q[$];
  int   done_q[$];
  ev_t  ev_q[$];

  logic [7:0] ma [16];
  logic [7:0] mb [16];

  task automatic chk(input string nm, input int c, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, c, got, exp);
    end
  endtask

  // Index-permutation model of one transform; pushes the first n_push cycles.
  task automatic push_run(input int c0, input int n_push);
    logic [7:0] na [16];
    logic [7:0] nb [16];
    logic [7:0] op [4];
    logic [7:0] res;
    run_t       e;
    int         s, g, k;
    na = ma;
    nb = mb;
    for (int c = 0; c < 32; c++) begin
      s = c >> 4;
      g = (c >> 2) & 3;
      k = c & 3;
      for (int n = 0; n < 4; n++) op[n] = (s != 0) ? nb[4*g + n] : na[g + 4*n];
      res = {4'h0, op[(k + 1) % 4][3:0]};
      if (c < n_push) begin
        e.cyc = c0 + c;
        e.xr  = {op[3][3:0], op[2][3:0], op[1][3:0], op[0][3:0]};
        e.xi  = {op[3][7:4], op[2][7:4], op[1][7:4], op[0][7:4]};
        e.ctl = {(s == 0) && (g != 0), k[1], k[0]};
        run_q.push_back(e);
      end
      if (s != 0) na[4*g + k] = res;
      else        nb[g + 4*k] = res;
    end
    if (n_push == 32) begin
      ma = na;
      mb = nb;
    end
  endtask

  task automatic push_ev(input int c, input int kind, input logic [7:0] v);
    ev_t e;
    e.cyc  = c;
    e.kind = kind;
    e.val  = v;
    ev_q.push_back(e);
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compares whatever the DUT presents against the queues.
  always @(negedge clk) begin
    run_t e;
    ev_t  v;
    int   dc;
    if (bus.busy) begin
      if (run_q.size() == 0) chk("busy_unexpected", cyc, 32'(bus.busy), 32'(0));
      else begin
        e = run_q.pop_front();
        chk("busy_cycle", cyc, 32'(cyc), 32'(e.cyc));
        chk("bf_xr", cyc, 32'({bus.bf_xr3, bus.bf_xr2, bus.bf_xr1, bus.bf_xr0}), 32'(e.xr));
        chk("bf_xi", cyc, 32'({bus.bf_xi3, bus.bf_xi2, bus.bf_xi1, bus.bf_xi0}), 32'(e.xi));
        chk("bf_ctl", cyc, 32'({bus.bf_c3, bus.bf_c2, bus.bf_c1}), 32'(e.ctl));
      end
    end
    if (bus.done) begin
      if (done_q.size() == 0) chk("done_unexpected", cyc, 32'(bus.done), 32'(0));
      else begin
        dc = done_q.pop_front();
        chk("done_cycle", cyc, 32'(cyc), 32'(dc));
      end
    end
    while (ev_q.size() != 0 && ev_q[0].cyc <= cyc) begin
      v = ev_q.pop_front();
      if (v.cyc < cyc) chk("event_missed", cyc, 32'(cyc), 32'(v.cyc));
      else if (v.kind == 0) chk("rd_data", cyc, 32'(bus.rd_data), 32'(v.val));
      else chk("all_zero", cyc,
               32'({bus.busy, bus.done, bus.rd_data, bus.bf_xr3, bus.bf_xr2, bus.bf_xr1,
                    bus.bf_xr0, bus.bf_c3, bus.bf_c2, bus.bf_c1}),
               32'({bus.bf_xi3, bus.bf_xi2, bus.bf_xi1, bus.bf_xi0}));
    end
    if (fin) begin
      while (run_q.size() != 0) begin
        e = run_q.pop_front();
        chk("busy_missing", e.cyc, 32'(0), 32'(1));
      end
      while (done_q.size() != 0) begin
        dc = done_q.pop_front();
        chk("done_missing", dc, 32'(0), 32'(1));
      end
      while (ev_q.size() != 0) begin
        v = ev_q.pop_front();
        chk("event_unchecked", v.cyc, 32'(0), 32'(1));
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  initial begin
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = 4'h0;
    bus.wr_data = 8'h00;
    bus.rd_addr = 4'h0;
    for (int i = 0; i < 16; i++) begin
      ma[i] = 8'h00;
      mb[i] = 8'h00;
    end
    push_ev(1, 1, 8'h00);

    // Start on the first edge after reset release; stray starts ignored.
    goto(3);
    rst_n     = 1'b1;
    bus.start = 1'b1;
    push_run(4, 32);
    done_q.push_back(36);
    goto(4);  bus.start = 1'b0;
    goto(20); bus.start = 1'b1;
    goto(21); bus.start = 1'b0;
    goto(36); bus.start = 1'b1;
    goto(37); bus.start = 1'b0;

    // Load A[n] = {0, n}, full transform, digit-reversed readback.
    goto(40);
    for (int n = 0; n < 16; n++) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = 4'(n);
      bus.wr_data = {4'h0, 4'(n)};
      ma[n]       = {4'h0, 4'(n)};
      goto(41 + n);
    end
    bus.wr_en   = 1'b0;
    bus.rd_addr = 4'b0110;
    push_ev(57, 0, 8'h09);
    goto(58);
    bus.start = 1'b1;
    push_run(59, 32);
    done_q.push_back(91);
    push_ev(70, 0, 8'h09);
    push_ev(92, 0, 8'h0E);
    goto(59); bus.start = 1'b0;
    goto(93);
    for (int a = 0; a < 16; a++) begin
      logic [3:0] ad;
      ad          = 4'(a);
      bus.rd_addr = ad;
      push_ev(94 + a, 0, ma[{ad[1:0], ad[3:2]}]);
      goto(94 + a);
    end

    // Abort in RUN cycle 7, then abort+start together in IDLE starts.
    goto(110);
    bus.start = 1'b1;
    push_run(111, 8);
    goto(111); bus.start = 1'b0;
    goto(118); bus.abort = 1'b1;
    goto(119); bus.abort = 1'b0;
    goto(122);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    push_run(123, 32);
    done_q.push_back(155);
    goto(123);
    bus.start = 1'b0;
    bus.abort = 1'b0;

    // Reset at RUN cycle 15 clears everything; loads work afterwards.
    goto(160);
    bus.start = 1'b1;
    push_run(161, 15);
    goto(161); bus.start = 1'b0;
    goto(176);
    rst_n = 1'b0;
    push_ev(176, 1, 8'h00);
    for (int i = 0; i < 16; i++) begin
      ma[i] = 8'h00;
      mb[i] = 8'h00;
    end
    goto(177);
    rst_n = 1'b1;
    for (int a = 0; a < 16; a++) begin
      bus.rd_addr = 4'(a);
      push_ev(178 + a, 0, 8'h00);
      goto(178 + a);
    end
    goto(194);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 4'd3;
    bus.wr_data = 8'hA5;
    bus.rd_addr = 4'b1100;
    push_ev(195, 0, 8'h00);
    push_ev(196, 0, 8'hA5);
    goto(195); bus.wr_en = 1'b0;

    goto(200);
    fin = 1'b1;
    goto(210);
    $display("FAIL monitor_stalled cyc=%0d got=running want=finished", cyc);
    $fatal(1);
  end
endmodule

// File: doc/r4_fft_sched.md
R4_FFT_SCHED -- requirements
Module: r4_fft_sched

Interface
REQ-001 SHALL have port wb_clk_i, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port wb_rst_ni, input, 1 bit: reset, asynchronous assert, active-low.
REQ-003 SHALL have port start, input, 1 bit: request a 16-point transform; sampled only in IDLE.
REQ-004 SHALL have port abort, input, 1 bit: cancel the transform in progress.
REQ-005 SHALL have port wr_en, input, 1 bit: sample load strobe.
REQ-006 SHALL have port wr_addr, input, 4 bits: sample index n.
REQ-007 SHALL have port wr_data, input, 8 bits: {imag[7:4], real[3:0]}, two's complement.
REQ-008 SHALL have port rd_addr, input, 4 bits: result bin k.
REQ-009 SHALL have port rd_data, output, 8 bits: registered result {imag, real}.
REQ-010 SHALL have port busy, output, 1 bit: high in RUN.
REQ-011 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have ports bf_xr0..bf_xr3 and bf_xi0..bf_xi3, each output, 4 bits: butterfly operands.
REQ-013 SHALL have ports bf_c1, bf_c2, bf_c3, each output, 1 bit: butterfly control.
REQ-014 SHALL have ports bf_xro and bf_xio, each input, 4 bits: butterfly result, combinational in the same cycle.

Function
REQ-015 Storage SHALL be two banks, A and B, each 16 x 8 bits.
REQ-016 Loads SHALL write bank A; wr_en SHALL be ignored outside IDLE.
REQ-017 FSM SHALL have states IDLE, RUN and DONE.
- IDLE to RUN on start=1.
- RUN to DONE after 32 RUN cycles.
- DONE to IDLE unconditionally after one cycle.
- RUN to IDLE on abort=1.
REQ-018 RUN SHALL step counters {s[0], g[1:0], k[1:0]} as a 5-bit up-counter.
- Starts at 0; k is the least significant field.
- Issues one butterfly output per cycle.
REQ-019 Stage 0 (s=0) SHALL read bank A, with operand n taken from index g+4n.
- Writes {bf_xio, bf_xro} to bank B index g+4k.
REQ-020 Stage 1 (s=1) SHALL read bank B, with operand n taken from index 4g+n.
- Writes to bank A index 4g+k.
REQ-021 Operands SHALL be driven combinationally from the bank contents during each RUN cycle.
- Driven all-zero outside RUN.
REQ-022 Control SHALL be bf_c1=k[0] and bf_c2=k[1].
- bf_c3=1 iff s=0 and g!=0 (twiddle apply); else 0.
- All three are 0 outside RUN.
REQ-023 Results SHALL be written unmodified; scaling and saturation are the datapath's job.
REQ-024 rd_data SHALL load bank A[{rd_addr[1:0], rd_addr[3:2]}] (digit reversal) each cycle in IDLE and DONE.
- Holds its value during RUN.
REQ-025 Latency: start sampled at edge T SHALL give busy=1 on cycles T+1..T+32 and done=1 on cycle T+33.
REQ-026 start SHALL be ignored in RUN and DONE; no queuing.
REQ-027 abort in RUN SHALL return to IDLE next cycle.
- No done pulse; counters cleared.
- Bank contents are whatever has been written so far.
REQ-028 abort and start asserted together in IDLE SHALL start the transform; abort has no effect outside RUN.
REQ-029 The counter SHALL wrap from 31 to 0 exactly at the RUN-to-DONE transition.

Reset
REQ-030 wb_rst_ni=0 SHALL asynchronously force:
- state IDLE, counters 0;
- busy=0, done=0, rd_data=0;
- all bf_* outputs 0;
- both banks cleared to 0.
REQ-031 Reset mid-RUN SHALL discard the transform; after release the block accepts loads and start normally.
REQ-032 The first start SHALL be honoured on the first rising edge after wb_rst_ni deasserts.

Verification
REQ-033 Load A[n]={0, n[3:0]}, pulse start.
- Stage 0, g=1: operands xr = 1, 5, 9, 13.
- bf_c3=1 and {c2, c1} steps 00, 01, 10, 11 over four cycles.
REQ-034 Bench butterfly model returns xro=operand k+1 and xio=0; full run.
- Bank A matches the index-permutation golden model.
- rd_addr=4'b0110 reads A[4'b1001].
REQ-035 Timing: start at cycle 10 gives busy on cycles 11..42, done only at cycle 43, then IDLE.
- A start at cycle 20 is ignored.
REQ-036 abort at RUN cycle 7: busy=0 next cycle, no done.
- A fresh start then performs a full 32-cycle run.
REQ-037 wb_rst_ni=0 at RUN cycle 15: all outputs 0 immediately.
- Reading every rd_addr returns 8'h00.
- wr_en with wr_data=8'hA5 at n=3, then rd_addr=4'b1100, returns 8'hA5.
